// File: rtl/stick_pkg.sv
// Shared types and constants for the joystick conditioning path.
package stick_pkg;
  localparam logic [7:0] CENTER = 8'h80;
  typedef logic [7:0] axis_t;
endpackage

// File: rtl/stick_axis.sv
// One analog axis: snaps near-centre samples to centre, then smooths with a
// first-order IIR whose weight is 1/2^SHIFT.
module stick_axis
  import stick_pkg::*;
#(
  parameter int unsigned SHIFT    = 2,
  parameter int unsigned DEADBAND = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  sample_valid,
  input  logic  force_center,
  input  axis_t raw,
  output axis_t data
);
  localparam int unsigned AW = 8 + SHIFT;
  localparam logic [AW-1:0] ACC_CENTER = AW'(CENTER) << SHIFT;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [8:0]    diff;
  logic [8:0]    mag;
  axis_t         snapped;

  always_comb begin
    diff     = {1'b0, raw} - {1'b0, CENTER};
    mag      = diff[8] ? (9'd0 - diff) : diff;
    snapped  = (mag <= 9'(DEADBAND)) ? CENTER : raw;
    // Peak steady value is 255<<SHIFT, so the add never wraps.
    acc_next = acc - (acc >> SHIFT) + AW'(snapped);
  end

  always_ff @(posedge clk) begin
    if (rst || force_center) begin
      acc <= ACC_CENTER;
    end else if (sample_valid) begin
      acc <= acc_next;
    end
  end

  assign data = acc[AW-1:SHIFT];
endmodule

// File: rtl/stick_conditioner.sv
// Conditions raw PS2 stick samples: per-axis deadband + IIR, button debounce
// with press pulses, and a stale-link watchdog that forces neutral outputs.
module stick_conditioner
  import stick_pkg::*;
#(
  parameter int unsigned SHIFT    = 2,
  parameter int unsigned DEADBAND = 8,
  parameter int unsigned STABLE   = 3,
  parameter int unsigned TIMEOUT  = 4_000_000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  sample_valid,
  input  axis_t raw_l_x,
  input  axis_t raw_l_y,
  input  axis_t raw_r_x,
  input  logic  raw_circle,
  input  logic  raw_square,
  output axis_t data_l_x,
  output axis_t data_l_y,
  output axis_t data_r_x,
  output logic  circle,
  output logic  square,
  output logic  circle_press,
  output logic  square_press,
  output logic  link_ok
);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(STABLE + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_FLIP = CW'(STABLE);

  logic [IW-1:0] idle;
  logic [IW-1:0] idle_next;
  logic          stale;

  logic [1:0]    raw_btn;
  logic [1:0]    level;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  // Looking at the next idle value lets a sample on the timeout cycle win.
  always_comb begin
    idle_next = idle;
    if (sample_valid) begin
      idle_next = '0;
    end else if (idle != IDLE_MAX) begin
      idle_next = idle + IW'(1);
    end
    stale = (idle_next == IDLE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle    <= '0;
      link_ok <= 1'b1;
    end else begin
      idle    <= idle_next;
      link_ok <= ~stale;
    end
  end

  assign raw_btn = {raw_square, raw_circle};

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (rst || stale) begin
        level[i] <= 1'b0;
        cnt[i]   <= '0;
        press[i] <= 1'b0;
      end else begin
        press[i] <= 1'b0;
        if (sample_valid) begin
          if (raw_btn[i] == level[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] + CW'(1) == CNT_FLIP) begin
            level[i] <= raw_btn[i];
            cnt[i]   <= '0;
            press[i] <= raw_btn[i];
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign circle       = level[0];
  assign square       = level[1];
  assign circle_press = press[0];
  assign square_press = press[1];

  stick_axis #(.SHIFT(SHIFT), .DEADBAND(DEADBAND)) u_l_x (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .force_center(stale),
    .raw(raw_l_x), .data(data_l_x)
  );

  stick_axis #(.SHIFT(SHIFT), .DEADBAND(DEADBAND)) u_l_y (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .force_center(stale),
    .raw(raw_l_y), .data(data_l_y)
  );

  stick_axis #(.SHIFT(SHIFT), .DEADBAND(DEADBAND)) u_r_x (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .force_center(stale),
    .raw(raw_r_x), .data(data_r_x)
  );
endmodule

// File: tb/tb_stick_conditioner.sv
// Drives directed and random stick traffic into stick_conditioner and compares
// every output each cycle against an arithmetic reference model.
module tb_stick_conditioner;
  localparam int SHIFT    = 2;
  localparam int DEADBAND = 8;
  localparam int STABLE   = 3;
  localparam int TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] raw_l_x = 8'h80, raw_l_y = 8'h80, raw_r_x = 8'h80;
  logic       raw_circle = 1'b0, raw_square = 1'b0;
  logic [7:0] data_l_x, data_l_y, data_r_x;
  logic       circle, square, circle_press, square_press, link_ok;

  stick_conditioner #(
    .SHIFT(SHIFT), .DEADBAND(DEADBAND), .STABLE(STABLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .raw_l_x(raw_l_x), .raw_l_y(raw_l_y), .raw_r_x(raw_r_x),
    .raw_circle(raw_circle), .raw_square(raw_square),
    .data_l_x(data_l_x), .data_l_y(data_l_y), .data_r_x(data_r_x),
    .circle(circle), .square(square),
    .circle_press(circle_press), .square_press(square_press),
    .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state: accumulators as plain integers (value * 2^SHIFT),
  // buttons as a level plus a run length of disagreeing samples.
  int acc_m [3];
  int run_m [2];
  bit lvl_m [2];
  bit press_m [2];
  bit link_m;
  int since_m;

  function automatic int snap(input int s);
    int d = s - 128;
    if (d < 0) d = -d;
    return (d <= DEADBAND) ? 128 : s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) acc_m[i] = 128 * (1 << SHIFT);
    for (int i = 0; i < 2; i++) begin
      run_m[i] = 0; lvl_m[i] = 0; press_m[i] = 0;
    end
    link_m  = 1;
    since_m = 0;
  endtask

  task automatic model_cycle(input bit r, input bit sv, input int ax[3], input bit bt[2]);
    if (r) begin
      model_reset();
      return;
    end
    since_m = sv ? 0 : ((since_m + 1 > TIMEOUT) ? TIMEOUT : since_m + 1);
    press_m[0] = 0;
    press_m[1] = 0;
    if (since_m >= TIMEOUT) begin
      model_reset();
      since_m = TIMEOUT;
      link_m  = 0;
      return;
    end
    link_m = 1;
    if (!sv) return;
    for (int i = 0; i < 3; i++)
      acc_m[i] = acc_m[i] - acc_m[i] / (1 << SHIFT) + snap(ax[i]);
    for (int i = 0; i < 2; i++) begin
      if (bt[i] == lvl_m[i]) run_m[i] = 0;
      else begin
        run_m[i]++;
        if (run_m[i] == STABLE) begin
          lvl_m[i]   = bt[i];
          run_m[i]   = 0;
          press_m[i] = bt[i];
        end
      end
    end
  endtask

  task automatic compare_all();
    check("l_x", data_l_x, acc_m[0] / (1 << SHIFT));
    check("l_y", data_l_y, acc_m[1] / (1 << SHIFT));
    check("r_x", data_r_x, acc_m[2] / (1 << SHIFT));
    check("circle", circle, lvl_m[0]);
    check("square", square, lvl_m[1]);
    check("circle_press", circle_press, press_m[0]);
    check("square_press", square_press, press_m[1]);
    check("link_ok", link_ok, link_m);
  endtask

  task automatic step(input bit r, input bit sv, input logic [7:0] lx, input logic [7:0] ly,
                      input logic [7:0] rx, input bit c, input bit s);
    int ax[3];
    bit bt[2];
    @(negedge clk);
    rst = r; sample_valid = sv;
    raw_l_x = lx; raw_l_y = ly; raw_r_x = rx;
    raw_circle = c; raw_square = s;
    ax[0] = lx; ax[1] = ly; ax[2] = rx;
    bt[0] = c; bt[1] = s;
    model_cycle(r, sv, ax, bt);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cycle();
    step(0, 0, 8'h80, 8'h80, 8'h80, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 8'h80, 8'h80, 8'h80, 0, 0);
  endtask

  initial begin
    bit rc, rs;
    int gap;
    model_reset();

    // Reset values
    do_reset();
    do_reset();
    check("rst_axis", data_l_x, 8'h80);
    check("rst_link", link_ok, 1);
    check("rst_press", circle_press, 0);

    // Deadband
    step(0, 1, 8'h80, 8'h80, 8'h86, 0, 0);
    check("db_in", data_r_x, 8'h80);
    step(0, 1, 8'h80, 8'h80, 8'h89, 0, 0);
    check("db_out", data_r_x, 8'h82);

    // IIR step response
    do_reset();
    step(0, 1, 8'hFF, 8'h80, 8'h80, 0, 0);
    check("iir_1", data_l_x, 159);
    step(0, 1, 8'hFF, 8'h80, 8'h80, 0, 0);
    check("iir_2", data_l_x, 183);

    // Debounce: short glitch, clean press, release
    do_reset();
    step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 0, 0);
    check("glitch_lvl", circle, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    check("pre_press", circle_press, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    check("press_lvl", circle, 1);
    check("press_pulse", circle_press, 1);
    idle_cycle();
    check("press_once", circle_press, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h80, 8'h80, 8'h80, 0, 0);
      check("release_nopulse", circle_press, 0);
    end
    check("release_lvl", circle, 0);

    // Watchdog timeout and recovery
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 8'h80, 8'hFF, 8'h80, 0, 1);
    check("wd_pre_sq", square, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) idle_cycle();
    check("wd_before", link_ok, 1);
    idle_cycle();
    check("wd_link", link_ok, 0);
    check("wd_axis", data_l_y, 8'h80);
    check("wd_sq", square, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 0, 0);
    check("wd_recover", link_ok, 1);

    // Sample arriving on the timeout cycle wins
    do_reset();
    step(0, 1, 8'h80, 8'hFF, 8'h80, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle_cycle();
    step(0, 1, 8'h80, 8'hFF, 8'h80, 0, 0);
    check("race_link", link_ok, 1);
    check("race_axis", data_l_y, 183);

    // Reset during a pulse cycle, and on the completing sample
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    check("rp_pulse", circle_press, 1);
    step(1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 1);
    check("rp_cleared", circle_press, 0);
    check("rp_lvl", circle, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    step(0, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    step(1, 1, 8'h80, 8'h80, 8'h80, 1, 0);
    check("rp_drop", circle_press, 0);

    // Random traffic with bursts, gaps long enough to go stale, and resets
    rc = 0; rs = 0; gap = 0;
    for (int n = 0; n < 4000; n++) begin
      bit r, sv;
      if ($urandom_range(0, 99) < 10) rc = ~rc;
      if ($urandom_range(0, 99) < 10) rs = ~rs;
      if (gap == 0 && $urandom_range(0, 199) == 0) gap = $urandom_range(10, 22);
      r  = ($urandom_range(0, 399) == 0);
      if (gap > 0) begin
        sv = 0;
        gap--;
      end else begin
        sv = ($urandom_range(0, 3) != 0);
      end
      step(r, sv, 8'($urandom), 8'($urandom_range(112, 144)), 8'($urandom), rc, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/stick_conditioner.md
# stick_conditioner

Conditions the raw PS2 joystick samples before they reach the paddle, angle and state-manager logic. It sits directly downstream of `ps2_stick` and upstream of `paddle`, `angle_controller` and `state_manager`. It applies a deadband and a first-order IIR filter to the three analog axes, debounces `circle`/`square` into clean levels plus one-cycle press pulses, and forces neutral outputs when the stick link goes stale.

## Interface

Parameters:
- `SHIFT`, 2 — IIR smoothing shift; filter weight is 1/2^SHIFT.
- `DEADBAND`, 8 — maximum |sample − 0x80| that is snapped to centre.
- `STABLE`, 3 — consecutive differing samples required to flip a button.
- `TIMEOUT`, 4_000_000 — cycles without `sample_valid` before the link is stale (100 ms at 40 MHz).

Ports:
- `clk` in 1 — 40 MHz system clock; all logic is on this edge.
- `rst` in 1 — synchronous, active-high reset.
- `sample_valid` in 1 — one-cycle strobe; raw inputs are valid this cycle.
- `raw_l_x`, `raw_l_y`, `raw_r_x` in 8 each — raw axes; 0x80 is centre.
- `raw_circle`, `raw_square` in 1 each — raw button levels; 1 = pressed.
- `data_l_x`, `data_l_y`, `data_r_x` out 8 each — filtered axes.
- `circle`, `square` out 1 each — debounced button levels.
- `circle_press`, `square_press` out 1 each — one-cycle pulse on each debounced 0→1 edge.
- `link_ok` out 1 — 0 while the link is stale.

## Operation

- Deadband per axis:
  - d = sample − 0x80, signed 9-bit.
  - If |d| ≤ DEADBAND, the sample is replaced by 0x80.
- IIR per axis:
  - Accumulator `acc` is 8+SHIFT bits, unsigned. Reset value is 0x80<<SHIFT.
  - On `sample_valid`: acc ← acc − (acc>>SHIFT) + s.
  - Output = acc>>SHIFT.
  - The accumulator never overflows or underflows, because the maximum steady value is 255<<SHIFT. No clamping is needed.
- Debounce per button:
  - State is a `stable` level plus a counter `cnt` of width clog2(STABLE+1).
  - On `sample_valid`:
    - If raw == stable, cnt ← 0.
    - Otherwise cnt ← cnt+1. When cnt reaches STABLE, stable flips and cnt ← 0.
  - A 0→1 flip asserts the press pulse for exactly one cycle. A 1→0 flip produces no pulse.
- Stale watchdog:
  - `idle` counter, width clog2(TIMEOUT+1), is cleared on every `sample_valid` and otherwise increments, saturating at TIMEOUT.
  - When `idle` == TIMEOUT, the block is in the STALE condition and, every cycle:
    - `link_ok` = 0;
    - all accumulators are forced to centre;
    - both buttons are forced released with cnt = 0;
    - no press pulses are produced.
  - The first `sample_valid` after STALE sets `link_ok` = 1 and is processed normally, starting from the centred state.
- Simultaneous events: if `sample_valid` arrives in the same cycle `idle` would reach TIMEOUT, the sample wins. It is processed, `idle` ← 0, and `link_ok` stays 1.

## Timing

- All outputs are registered. A `sample_valid` in cycle t is reflected on the outputs in cycle t+1.
- A press pulse is high in exactly cycle t+1 of the sample that completes the flip.
- Reset values:
  - axes = 0x80;
  - `circle` = `square` = 0;
  - press pulses = 0;
  - `link_ok` = 1;
  - all counters = 0.
- Reset asserted mid-operation returns every register to its reset value on the next edge. Any pending pulse is dropped.
- `sample_valid` held high on consecutive cycles means one sample per cycle. There is no backpressure.

## Structure

- Package `stick_pkg`:
  - `localparam CENTER = 8'h80`;
  - `typedef logic [7:0] axis_t`.
- Sub-module `stick_axis`: deadband plus IIR for a single axis, with a centring `force_center` input. It is instantiated three times.
- Button debounce (×2) and the watchdog are inline in the top of the block.

## Test plan

- Deadband:
  - After reset, drive `raw_r_x` = 0x86 with `sample_valid` → `data_r_x` stays 0x80.
  - Then drive 0x89 → `data_r_x` = 0x82 (acc 521).
- IIR step: drive two samples of `raw_l_x` = 0xFF → `data_l_x` = 159 (0x9F), then 183 (0xB7), each one cycle after its strobe.
- Debounce:
  - Drive `raw_circle` = 1 for 2 samples, then 0 → no flip, no pulse.
  - Then drive 3 samples of 1 → `circle` = 1 and `circle_press` high for exactly one cycle after the third strobe.
  - Then drive 3 samples of 0 → `circle` falls with no pulse.
- Watchdog:
  - With TIMEOUT = 16 and `data_l_y` ≠ 0x80, `square` = 1, withhold `sample_valid` for 16 cycles → `link_ok` = 0, axes = 0x80, `square` = 0.
  - The next strobe → `link_ok` = 1.
- Race: `sample_valid` on the exact cycle `idle` reaches 16 → `link_ok` never drops and the sample is filtered normally.
- Reset mid-run: assert `rst` during a press pulse cycle → next cycle all outputs hold their reset values and no pulse is seen.
